// File: rtl/cve2_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cve2_mem_pkg
// Description : Shared types and legal parameter ranges for the OBI memory
//               responder and its response pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package cve2_mem_pkg;

   // One response beat as it travels down the latency pipeline.
   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } mem_rsp_t;

   localparam int unsigned MaxWaitStates  = 15;
   localparam int unsigned MaxReadLatency = 4;

endpackage : cve2_mem_pkg
`default_nettype wire

// File: rtl/cve2_mem_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cve2_mem_rsp_pipe
// Description : Fixed-depth shift register of response beats with synchronous
//               clear. Advances every cycle; there is no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module cve2_mem_rsp_pipe
   import cve2_mem_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  mem_rsp_t rsp_i,
   output mem_rsp_t rsp_o
);

   mem_rsp_t r_stage [Depth];

   // Stage 0 captures the beat formed in the grant cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stage[0] <= '0;
      end else begin
         r_stage[0] <= rsp_i;
      end
   end

   for (genvar i = 1; i < Depth; i++) begin : g_stage
      // Each further stage simply follows its predecessor.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_stage[i] <= '0;
         end else begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign rsp_o = r_stage[Depth-1];

endmodule : cve2_mem_rsp_pipe
`default_nettype wire

// File: rtl/cve2_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cve2_obi_mem_responder
// Description : Request/grant/rvalid memory responder with programmable grant
//               wait states, byte-enabled word SRAM and fixed read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module cve2_obi_mem_responder
   import cve2_mem_pkg::*;
#(
   parameter int unsigned DepthWords  = 1024,
   parameter logic [31:0] BaseAddr    = 32'h0000_0000,
   parameter int unsigned WaitStates  = 0,
   parameter int unsigned ReadLatency = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   input  logic        stall_i
);

   localparam int unsigned c_idx_w     = $clog2(DepthWords);
   localparam logic [3:0]  c_wait      = 4'(WaitStates);
   localparam logic [31:0] c_span      = 32'(4 * DepthWords);

   if (WaitStates > MaxWaitStates) begin : g_bad_wait
      $error("cve2_obi_mem_responder: WaitStates out of range");
   end
   if ((ReadLatency < 1) || (ReadLatency > MaxReadLatency)) begin : g_bad_lat
      $error("cve2_obi_mem_responder: ReadLatency out of range");
   end

   logic [3:0]         r_wait_q;
   logic [31:0]        w_offset;
   logic               w_in_range;
   logic [c_idx_w-1:0] w_index;
   logic               w_wr_en;
   mem_rsp_t           w_rsp;
   mem_rsp_t           w_rsp_out;
   logic [31:0]        r_mem [DepthWords];

   // Grant is combinational so a zero-wait configuration grants in the request cycle.
   assign gnt_o = req_i & ~stall_i & ~rst_i & (r_wait_q == c_wait);

   // Wait counter: restarts on grant or when the request drops, saturates otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i || !req_i || gnt_o) begin
         r_wait_q <= '0;
      end else if (r_wait_q != c_wait) begin
         r_wait_q <= r_wait_q + 4'd1;
      end
   end

   // Offset wraps for addresses below the base, so one unsigned compare covers both ends.
   assign w_offset   = addr_i - BaseAddr;
   assign w_in_range = (w_offset < c_span);
   assign w_index    = w_offset[c_idx_w+1:2];
   assign w_wr_en    = gnt_o & we_i & w_in_range;

   // Byte-lane write; commits at the grant edge so a read granted next cycle sees it.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               r_mem[w_index][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Response beat formed in the grant cycle; data only for in-range reads.
   always_comb begin
      w_rsp       = '0;
      w_rsp.valid = gnt_o;
      w_rsp.err   = gnt_o & ~w_in_range;
      w_rsp.rdata = (gnt_o && !we_i && w_in_range) ? r_mem[w_index] : 32'h0;
   end

   cve2_mem_rsp_pipe #(
      .Depth (ReadLatency)
   ) u_rsp_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .rsp_i (w_rsp),
      .rsp_o (w_rsp_out)
   );

   assign rvalid_o = w_rsp_out.valid;
   assign err_o    = w_rsp_out.err;
   assign rdata_o  = w_rsp_out.rdata;

endmodule : cve2_obi_mem_responder
`default_nettype wire

// File: tb/tb_cve2_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cve2_obi_mem_responder
// Description : Scoreboard bench for three responder configurations:
//               inst 0 WaitStates=0/ReadLatency=1, inst 1 3/4,
//               inst 2 0/3 with BaseAddr 0x8000_0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cve2_obi_mem_responder;

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  req;
   logic [2:0]  gnt;
   logic [2:0]  we;
   logic [2:0]  rvalid;
   logic [2:0]  err;
   logic [2:0]  stall;
   logic [3:0]  be    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];

   exp_t q [3][$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      cve2_obi_mem_responder #(
         .DepthWords  (1024),
         .BaseAddr    ((g == 2) ? 32'h8000_0000 : 32'h0000_0000),
         .WaitStates  ((g == 1) ? 3 : 0),
         .ReadLatency ((g == 0) ? 1 : (g == 1) ? 4 : 3)
      ) u_dut (
         .clk_i    (clk),
         .rst_i    (rst[g]),
         .req_i    (req[g]),
         .gnt_o    (gnt[g]),
         .addr_i   (addr[g]),
         .we_i     (we[g]),
         .be_i     (be[g]),
         .wdata_i  (wdata[g]),
         .rvalid_o (rvalid[g]),
         .rdata_o  (rdata[g]),
         .err_o    (err[g]),
         .stall_i  (stall[g])
      );

      // Monitor: every rvalid pops the oldest expected response and checks it.
      always @(negedge clk) begin
         exp_t e;
         if (rvalid[g]) begin
            n_cmp++;
            if (q[g].size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_rvalid inst=%0d cycle=%0d got rdata=%h err=%b, required no response",
                        g, cyc, rdata[g], err[g]);
            end else begin
               e = q[g].pop_front();
               if (cyc != e.cyc || err[g] !== e.err || rdata[g] !== e.rdata) begin
                  n_fail++;
                  $display("FAIL response inst=%0d got cycle=%0d rdata=%h err=%b, required cycle=%0d rdata=%h err=%b",
                           g, cyc, rdata[g], err[g], e.cyc, e.rdata, e.err);
               end
            end
         end
      end
   end

   function automatic int rl_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : 3;
   endfunction

   // Issue one request, hold it until granted, check grant wait, queue expected response.
   task automatic access(input int k, input bit we_v, input logic [31:0] a, input logic [3:0] be_v,
                         input logic [31:0] wd, input int exp_wait, input int st,
                         input bit e_err, input logic [31:0] e_rd);
      int   n;
      exp_t e;
      req[k]   = 1'b1;
      we[k]    = we_v;
      addr[k]  = a;
      be[k]    = be_v;
      wdata[k] = wd;
      stall[k] = (st > 0);
      n = 0;
      forever begin
         @(negedge clk);
         if (gnt[k]) break;
         if (n >= 40) break;
         @(posedge clk);
         #1;
         n++;
         if (n >= st) stall[k] = 1'b0;
      end
      n_cmp++;
      if (!gnt[k]) begin
         n_fail++;
         $display("FAIL gnt_timeout inst=%0d addr=%h got no grant in 40 cycles, required grant after %0d",
                  k, a, exp_wait);
         req[k]   = 1'b0;
         stall[k] = 1'b0;
      end else begin
         if (n != exp_wait) begin
            n_fail++;
            $display("FAIL gnt_wait inst=%0d addr=%h got %0d wait cycles, required %0d", k, a, n, exp_wait);
         end
         e.cyc   = cyc + rl_of(k);
         e.err   = e_err;
         e.rdata = e_rd;
         q[k].push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      req[k]   = 1'b0;
      we[k]    = 1'b0;
      stall[k] = 1'b0;
   endtask

   task automatic check_quiet(input int k, input string name);
      n_cmp++;
      if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s inst=%0d got gnt=%b rvalid=%b rdata=%h err=%b, required all 0",
                  name, k, gnt[k], rvalid[k], rdata[k], err[k]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; req[k] = 1'b1; we[k] = 1'b0; stall[k] = 1'b0;
         be[k] = 4'hF; addr[k] = 32'h0; wdata[k] = 32'h0;
      end
      addr[2] = 32'h8000_0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_quiet(k, "reset_state");
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b0;
         idle(k);
      end
      @(posedge clk);
      #1;

      // Instance 0: zero wait, latency 1.
      access(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 32'h0);
      access(0, 0, 32'h10, 4'hF, 32'h0,        0, 0, 0, 32'hDEADBEEF);
      access(0, 1, 32'h10, 4'b0001, 32'h55,    0, 0, 0, 32'h0);
      access(0, 0, 32'h10, 4'hF, 32'h0,        0, 0, 0, 32'hDEADBE55);
      access(0, 1, 32'h0,  4'hF, 32'h11223344, 0, 0, 0, 32'h0);
      access(0, 0, 32'h1000, 4'hF, 32'h0,      0, 0, 1, 32'h0);
      access(0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF, 0, 0, 1, 32'h0);
      access(0, 0, 32'h0,  4'hF, 32'h0,        0, 0, 0, 32'h11223344);
      access(0, 0, 32'h13, 4'h0, 32'h0,        0, 0, 0, 32'hDEADBE55);
      idle(0);

      // Instance 1: three wait states, latency 4, back-to-back every 4 cycles.
      access(1, 1, 32'h4, 4'hF,    32'hCAFEF00D, 3, 0, 0, 32'h0);
      access(1, 0, 32'h4, 4'hF,    32'h0,        3, 0, 0, 32'hCAFEF00D);
      access(1, 1, 32'h4, 4'b1010, 32'h11223344, 3, 0, 0, 32'h0);
      access(1, 0, 32'h4, 4'hF,    32'h0,        3, 0, 0, 32'h11FE330D);
      idle(1);
      repeat (6) @(posedge clk);
      #1;
      // Reset one cycle after a read grant: the in-flight response must vanish.
      access(1, 0, 32'h4, 4'hF, 32'h0, 3, 0, 0, 32'h11FE330D);
      idle(1);
      rst[1] = 1'b1;
      q[1].delete();
      @(posedge clk);
      #1;
      rst[1] = 1'b0;
      @(negedge clk);
      check_quiet(1, "post_reset");
      repeat (6) @(posedge clk);
      #1;
      access(1, 0, 32'h4, 4'hF, 32'h0, 3, 0, 0, 32'h11FE330D);
      idle(1);

      // Instance 2: streaming at base 0x8000_0000, latency 3, 2-cycle stall.
      for (int i = 0; i < 8; i++)
         access(2, 1, 32'h8000_0000 + 32'(4*i), 4'hF, {4{8'(i+1)}}, 0, 0, 0, 32'h0);
      for (int i = 0; i < 8; i++)
         access(2, 0, 32'h8000_0000 + 32'(4*i), 4'hF, 32'h0, (i == 4) ? 2 : 0, (i == 4) ? 2 : 0,
                0, {4{8'(i+1)}});
      access(2, 0, 32'h7FFF_FFFC, 4'hF, 32'h0, 0, 0, 1, 32'h0);
      access(2, 0, 32'h8000_1000, 4'hF, 32'h0, 0, 0, 1, 32'h0);
      idle(2);

      repeat (10) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (q[k].size() != 0) begin
            n_fail++;
            $display("FAIL missing_rsp inst=%0d got %0d responses outstanding, required 0", k, q[k].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_cve2_obi_mem_responder
`default_nettype wire
